// File: rtl/game_pkg.sv
// Shared state encoding, screen geometry and field widths for the frog game.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CELL     = 32;
  localparam int SPAWN_X  = 320;
  localparam int SPAWN_Y  = 448;

  localparam int POS_W    = 10;
  localparam int LEVEL_W  = 3;
  localparam int LIVES_W  = 2;
  localparam int SPEED_W  = 4;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ATTRACT   = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Frog/collision/renderer inputs and game status outputs of the sequencer.
interface game_ctrl_if
  import game_pkg::*;
#(
  parameter int SCORE_W = 10
);
  logic                 frame_tick;
  logic                 start;
  logic                 collision;
  logic [POS_W-1:0]     frog_y;

  logic                 move_en;
  logic                 frog_respawn;
  logic [LIVES_W-1:0]   lives;
  logic [LEVEL_W-1:0]   level;
  logic [SPEED_W-1:0]   obstacle_speed;
  logic [SCORE_W-1:0]   score;
  logic [STATE_W-1:0]   game_state;

  modport master (
    output frame_tick, start, collision, frog_y,
    input  move_en, frog_respawn, lives, level, obstacle_speed, score, game_state
  );

  modport slave (
    input  frame_tick, start, collision, frog_y,
    output move_en, frog_respawn, lives, level, obstacle_speed, score, game_state
  );
endinterface

// File: rtl/game_ctrl_frame_timer.sv
// Frame down-counter for the DYING and LEVEL_UP waits; load has priority over tick.
// done is combinational: asserted on a frame_tick while the count sits at zero.
module frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (frame_tick && count != '0)
      count <= count - W'(1);
  end

  assign done = frame_tick && (count == '0);

endmodule

// File: rtl/game_ctrl.sv
// Frog game sequencer: state, lives, level, score and respawn; outputs registered, one cycle
// after trigger. Gameplay evaluates only on frame_tick.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [LIVES_W-1:0] LIVES_INIT   = 2'd3,
  parameter int                 DEATH_FRAMES = 60,
  parameter int                 WIN_FRAMES   = 90,
  parameter logic [POS_W-1:0]   GOAL_Y       = 10'd0,
  parameter logic [POS_W-1:0]   START_Y      = POS_W'(SPAWN_Y),
  parameter logic [LEVEL_W-1:0] MAX_LEVEL    = 3'd7,
  parameter int                 GOAL_BONUS   = 10,
  parameter int                 SCORE_W      = 10
) (
  input  logic       clk,
  input  logic       reset,
  game_ctrl_if.slave gif
);

  localparam int TMR_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [POS_W-1:0]     best_y_q, best_y_d;
  logic [SPEED_W-1:0]   speed_q;
  logic                 respawn_q, respawn_d;
  logic                 move_en_q;
  logic                 start_prev;
  logic                 start_edge;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_done;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // Sampled on every edge, reset included, so a start switch held high across
  // reset release does not count as a fresh press.
  always_ff @(posedge clk) start_prev <= gif.start;

  assign start_edge = gif.start & ~start_prev;

  frame_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (gif.frame_tick),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .done       (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    score_d   = score_q;
    best_y_d  = best_y_q;
    respawn_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_edge) begin
          lives_d   = LIVES_INIT;
          level_d   = '0;
          score_d   = '0;
          best_y_d  = START_Y;
          respawn_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A tick landing on the respawn cycle belongs to the transition.
        if (gif.frame_tick && !respawn_q) begin
          if (gif.collision) begin
            state_d  = ST_DYING;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(DEATH_FRAMES - 1);
          end else if (gif.frog_y <= GOAL_Y) begin
            score_d  = sat_add(score_q, GOAL_BONUS);
            state_d  = ST_LEVEL_UP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(WIN_FRAMES - 1);
          end else if (gif.frog_y < best_y_q) begin
            score_d  = sat_add(score_q, 1);
            best_y_d = gif.frog_y;
          end
        end
      end
      ST_DYING: begin
        if (tmr_done) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d   = lives_q - LIVES_W'(1);
            best_y_d  = START_Y;
            respawn_d = 1'b1;
            state_d   = ST_PLAY;
          end
        end
      end
      ST_LEVEL_UP: begin
        if (tmr_done) begin
          level_d   = (level_q >= MAX_LEVEL) ? level_q : level_q + LEVEL_W'(1);
          best_y_d  = START_Y;
          respawn_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ATTRACT;
      lives_q   <= '0;
      level_q   <= '0;
      score_q   <= '0;
      best_y_q  <= START_Y;
      respawn_q <= 1'b0;
      move_en_q <= 1'b0;
      speed_q   <= SPEED_W'(1);
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      score_q   <= score_d;
      best_y_q  <= best_y_d;
      respawn_q <= respawn_d;
      move_en_q <= (state_d == ST_PLAY);
      speed_q   <= SPEED_W'(level_d) + SPEED_W'(1);
    end
  end

  assign gif.game_state     = state_q;
  assign gif.lives          = lives_q;
  assign gif.level          = level_q;
  assign gif.score          = score_q;
  assign gif.frog_respawn   = respawn_q;
  assign gif.move_en        = move_en_q;
  assign gif.obstacle_speed = speed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: vector table, directed multi-cycle sequences, random play vs. reference model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int SW   = 10;
  localparam int SMAX = (1 << SW) - 1;
  localparam int DF   = 60;
  localparam int WF   = 90;
  localparam int SY   = 448;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   st_lvl = 1'b0;

  game_ctrl_if #(.SCORE_W(SW)) gif();

  game_ctrl #(.SCORE_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_cnt = 0;

  // Reference model: mode 0..4 as in the game_state encoding.
  int m_mode, m_lives, m_level, m_score, m_best, m_ticks;
  bit m_resp, m_prev;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(input bit s);
    m_mode = 0; m_lives = 0; m_level = 0; m_score = 0;
    m_best = SY; m_ticks = 0; m_resp = 1'b0; m_prev = s;
  endfunction

  function automatic void model_step(input bit t, input bit s, input bit c, input int y);
    bit pressed, was_resp;
    pressed  = s && !m_prev;
    was_resp = m_resp;
    m_prev   = s;
    m_resp   = 1'b0;
    case (m_mode)
      0, 4: if (pressed) begin
        m_lives = 3; m_level = 0; m_score = 0; m_best = SY; m_resp = 1'b1; m_mode = 1;
      end
      1: if (t && !was_resp) begin
        if (c) begin
          m_mode = 2; m_ticks = 0;
        end else if (y == 0) begin
          m_score = (m_score + 10 > SMAX) ? SMAX : m_score + 10;
          m_mode = 3; m_ticks = 0;
        end else if (y < m_best) begin
          m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
          m_best = y;
        end
      end
      2: if (t) begin
        m_ticks++;
        if (m_ticks == DF) begin
          if (m_lives == 1) begin
            m_lives = 0; m_mode = 4;
          end else begin
            m_lives--; m_best = SY; m_resp = 1'b1; m_mode = 1;
          end
        end
      end
      3: if (t) begin
        m_ticks++;
        if (m_ticks == WF) begin
          m_level = (m_level == 7) ? 7 : m_level + 1;
          m_best = SY; m_resp = 1'b1; m_mode = 1;
        end
      end
      default: m_mode = 0;
    endcase
  endfunction

  task automatic check_all();
    chk("model_state",   int'(gif.game_state),     m_mode);
    chk("model_lives",   int'(gif.lives),          m_lives);
    chk("model_level",   int'(gif.level),          m_level);
    chk("model_speed",   int'(gif.obstacle_speed), m_level + 1);
    chk("model_score",   int'(gif.score),          m_score);
    chk("model_move_en", int'(gif.move_en),        (m_mode == 1) ? 1 : 0);
    chk("model_respawn", int'(gif.frog_respawn),   int'(m_resp));
    resp_cnt += int'(gif.frog_respawn);
  endtask

  // Drive one cycle (called just after a rising edge), update model at the edge, check after it.
  task automatic clk_step(input bit t, input bit c, input int y);
    gif.frame_tick = t;
    gif.start      = st_lvl;
    gif.collision  = c;
    gif.frog_y     = 10'(y);
    @(posedge clk);
    if (reset) model_reset(st_lvl);
    else       model_step(t, st_lvl, c, y);
    #1;
    check_all();
  endtask

  // An idle cycle followed by a tick cycle; outputs afterwards reflect the tick.
  task automatic frame(input bit c, input int y);
    clk_step(1'b0, c, y);
    clk_step(1'b1, c, y);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   int'(gif.game_state),     0);
    chk({tag, "_move_en"}, int'(gif.move_en),        0);
    chk({tag, "_respawn"}, int'(gif.frog_respawn),   0);
    chk({tag, "_lives"},   int'(gif.lives),          0);
    chk({tag, "_level"},   int'(gif.level),          0);
    chk({tag, "_speed"},   int'(gif.obstacle_speed), 1);
    chk({tag, "_score"},   int'(gif.score),          0);
  endtask

  typedef struct {
    bit t; bit s; bit c; int y;
    int e_state; int e_lives; int e_score; bit e_move; bit e_resp;
  } vec_t;

  vec_t vt[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Start press, five idle frames, then progress scoring with revisited rows.
    vt[0]  = '{0, 1, 0, 448, 1, 3, 0, 1, 1};
    vt[1]  = '{0, 1, 0, 448, 1, 3, 0, 1, 0};
    for (int i = 2; i < 7; i++) vt[i] = '{1, 1, 0, 448, 1, 3, 0, 1, 0};
    vt[7]  = '{1, 1, 0, 416, 1, 3, 1, 1, 0};
    vt[8]  = '{1, 1, 0, 384, 1, 3, 2, 1, 0};
    vt[9]  = '{1, 1, 0, 416, 1, 3, 2, 1, 0};
    vt[10] = '{1, 1, 0, 384, 1, 3, 2, 1, 0};
    vt[11] = '{1, 1, 0, 400, 1, 3, 2, 1, 0};
    vt[12] = '{1, 1, 0, 352, 1, 3, 3, 1, 0};

    gif.frame_tick = 1'b0; gif.start = 1'b0; gif.collision = 1'b0; gif.frog_y = 10'd448;
    model_reset(1'b0);
    repeat (3) clk_step(1'b0, 1'b0, SY);
    chk_reset_vals("reset");
    reset = 1'b0;
    resp_cnt = 0;

    foreach (vt[i]) begin
      st_lvl = vt[i].s;
      clk_step(vt[i].t, vt[i].c, vt[i].y);
      chk($sformatf("vec%0d_state", i),   int'(gif.game_state),   vt[i].e_state);
      chk($sformatf("vec%0d_lives", i),   int'(gif.lives),        vt[i].e_lives);
      chk($sformatf("vec%0d_score", i),   int'(gif.score),        vt[i].e_score);
      chk($sformatf("vec%0d_move", i),    int'(gif.move_en),      int'(vt[i].e_move));
      chk($sformatf("vec%0d_respawn", i), int'(gif.frog_respawn), int'(vt[i].e_resp));
    end
    chk("start_respawn_count", resp_cnt, 1);

    // Three deaths: two respawns, then game over.
    resp_cnt = 0;
    for (int d = 0; d < 3; d++) begin
      frame(1'b1, SY);
      chk("die_state", int'(gif.game_state), 2);
      chk("die_move_en", int'(gif.move_en), 0);
      repeat (DF - 1) frame(1'b0, SY);
      chk("dying_hold_state", int'(gif.game_state), 2);
      frame(1'b0, SY);
      chk("after_death_lives", int'(gif.lives), 2 - d);
      chk("after_death_state", int'(gif.game_state), (d == 2) ? 4 : 1);
      chk("after_death_respawn", int'(gif.frog_respawn), (d == 2) ? 0 : 1);
    end
    clk_step(1'b0, 1'b0, SY);
    chk("death_respawn_count", resp_cnt, 2);

    // Collision beats goal; then a real goal and the level-up wait.
    st_lvl = 1'b0; clk_step(1'b0, 1'b0, SY);
    st_lvl = 1'b1; clk_step(1'b0, 1'b0, SY);
    chk("restart_state", int'(gif.game_state), 1);
    chk("restart_score", int'(gif.score), 0);
    frame(1'b1, 0);
    chk("coll_goal_state", int'(gif.game_state), 2);
    chk("coll_goal_score", int'(gif.score), 0);
    repeat (DF) frame(1'b0, SY);
    frame(1'b0, 0);
    chk("goal_score", int'(gif.score), 10);
    chk("goal_state", int'(gif.game_state), 3);
    repeat (WF - 1) frame(1'b0, SY);
    chk("levelup_hold_level", int'(gif.level), 0);
    frame(1'b0, SY);
    chk("levelup_level", int'(gif.level), 1);
    chk("levelup_speed", int'(gif.obstacle_speed), 2);
    chk("levelup_lives", int'(gif.lives), 2);
    chk("levelup_respawn", int'(gif.frog_respawn), 1);

    // Fresh game: level and score saturation through repeated goals.
    st_lvl = 1'b0; reset = 1'b1; clk_step(1'b0, 1'b0, SY);
    reset = 1'b0; st_lvl = 1'b1; clk_step(1'b0, 1'b0, SY);
    for (int g = 1; g <= 103; g++) begin
      frame(1'b0, 0);
      repeat (WF) frame(1'b0, SY);
      if (g == 8) begin
        chk("sat_level", int'(gif.level), 7);
        chk("sat_speed", int'(gif.obstacle_speed), 8);
        chk("score_8_goals", int'(gif.score), 80);
      end
      if (g == 102) chk("score_preload", int'(gif.score), 1020);
    end
    chk("score_saturated", int'(gif.score), 1023);
    chk("sat_level_late", int'(gif.level), 7);

    // Async reset in DYING with timer at 30, start held high through release.
    frame(1'b1, SY);
    repeat (29) frame(1'b0, SY);
    chk("pre_reset_state", int'(gif.game_state), 2);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    model_reset(st_lvl);
    resp_cnt = 0;
    repeat (2) clk_step(1'b1, 1'b0, SY);
    reset = 1'b0;
    repeat (4) clk_step(1'b1, 1'b0, SY);
    chk("held_start_state", int'(gif.game_state), 0);
    chk("reset_respawn_count", resp_cnt, 0);
    st_lvl = 1'b0; clk_step(1'b0, 1'b0, SY);
    st_lvl = 1'b1; clk_step(1'b0, 1'b0, SY);
    chk("repress_state", int'(gif.game_state), 1);

    // Random play against the model.
    st_lvl = 1'b0; reset = 1'b1; clk_step(1'b0, 1'b0, SY);
    reset = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) st_lvl = ~st_lvl;
      clk_step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 15)) * 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
